// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game sequencer.
package ttt_pkg;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_MOVE = 2'd1,
      S_CHECK     = 2'd2,
      S_DONE      = 2'd3
   } state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_A    = 2'b01;
   localparam logic [1:0] WIN_B    = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   localparam logic [8:0] FULL_BOARD = 9'h1FF;

   // One-hot board bit for a cell index; callers guarantee pos <= 8.
   function automatic logic [8:0] cell_mask(input logic [3:0] pos);
      return 9'd1 << pos;
   endfunction

endpackage

// File: rtl/ttt_move_timer.sv
// Per-turn move timer: counts WAIT_MOVE cycles and flags expiry on the last one.
// Only instantiated when TTT_MOVE_TIMEOUT_EN is defined.
module ttt_move_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clear,
   output logic expire
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt;

   // A handshake or start in the final cycle suppresses expiry.
   assign expire = run && !clear && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     cnt <= '0;
      else if (!run || clear || expire) cnt <= '0;
      else                            cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/ttt_game_sequencer.sv
// Tic-tac-toe game sequencer: accepts alternating moves, keeps both boards and
// resolves win/draw from an external win detector. Optional move timer via TTT_MOVE_TIMEOUT_EN.
module ttt_game_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       move_valid,
   input  logic [3:0] move_pos,
   output logic       move_ready,
   output logic [8:0] ain,
   output logic [8:0] bin,
   input  logic [7:0] win_line,
   output logic       turn,
   output logic       illegal,
   output logic       timeout,
   output logic       game_over,
   output logic [1:0] winner
);
   import ttt_pkg::*;

   state_t     state, next_state;
   logic [8:0] occupied, mover_mask;
   logic       in_range, legal, hs, expire;

   assign occupied   = ain | bin;
   assign in_range   = (move_pos <= 4'd8);
   assign mover_mask = in_range ? cell_mask(move_pos) : '0;
   assign legal      = in_range && ((occupied & mover_mask) == '0);
   assign hs         = move_valid && move_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (start) next_state = S_WAIT_MOVE;
      else begin
         case (state)
            S_IDLE:      next_state = S_IDLE;
            S_WAIT_MOVE: if (hs && legal) next_state = S_CHECK;
            S_CHECK:     next_state = ((win_line != '0) || (occupied == FULL_BOARD)) ? S_DONE : S_WAIT_MOVE;
            S_DONE:      next_state = S_DONE;
            default:     next_state = S_IDLE;
         endcase
      end
   end

   always_comb begin
      move_ready = (state == S_WAIT_MOVE);
      game_over  = (state == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ain     <= '0;
         bin     <= '0;
         turn    <= 1'b0;
         winner  <= WIN_NONE;
         illegal <= 1'b0;
      end else begin
         illegal <= 1'b0;
         if (start) begin
            ain    <= '0;
            bin    <= '0;
            turn   <= 1'b0;
            winner <= WIN_NONE;
         end else begin
            case (state)
               S_WAIT_MOVE: begin
                  if (hs) begin
                     if (!legal)    illegal <= 1'b1;
                     else if (turn) bin     <= bin | mover_mask;
                     else           ain     <= ain | mover_mask;
                  end else if (expire) begin
                     turn <= ~turn;
                  end
               end
               // A win outranks a full board so a ninth-move win is not a draw.
               S_CHECK: begin
                  if (win_line != '0)              winner <= turn ? WIN_B : WIN_A;
                  else if (occupied == FULL_BOARD) winner <= WIN_DRAW;
                  else                             turn   <= ~turn;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef TTT_MOVE_TIMEOUT_EN
   ttt_move_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .run    (state == S_WAIT_MOVE),
      .clear  (start || hs),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) timeout <= 1'b0;
      else        timeout <= expire;
   end
`else
   assign expire  = 1'b0;
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ttt_game_sequencer.sv
// Directed bench for ttt_game_sequencer with a behavioural win detector.
module tb_ttt_game_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, move_valid;
   logic [3:0] move_pos;
   logic       move_ready, turn, illegal, timeout, game_over;
   logic [8:0] ain, bin;
   logic [7:0] win_line;
   logic [1:0] winner;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ttt_game_sequencer #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .move_valid(move_valid),
      .move_pos(move_pos), .move_ready(move_ready), .ain(ain), .bin(bin),
      .win_line(win_line), .turn(turn), .illegal(illegal), .timeout(timeout),
      .game_over(game_over), .winner(winner)
   );

   // External win detector: rows, columns, diagonals (cell 8 = top-left).
   function automatic logic [7:0] lines_of(input logic [8:0] b);
      logic [8:0] m [8];
      logic [7:0] r;
      m = '{9'h1C0, 9'h038, 9'h007, 9'h124, 9'h092, 9'h049, 9'h111, 9'h054};
      r = '0;
      for (int i = 0; i < 8; i++) r[i] = ((b & m[i]) == m[i]);
      return r;
   endfunction

   always_comb win_line = lines_of(ain) | lines_of(bin);

   typedef struct {
      logic       st;
      logic       mv;
      logic [3:0] pos;
      logic [8:0] a;
      logic [8:0] b;
      logic       t;
      logic       ill;
      logic [1:0] w;
      logic       ov;
      logic       rdy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic st, mv, input logic [3:0] pos, input logic [8:0] a, b,
                              input logic t, ill, input logic [1:0] w, input logic ov, rdy);
      vec_t r;
      r.st = st; r.mv = mv; r.pos = pos; r.a = a; r.b = b;
      r.t = t; r.ill = ill; r.w = w; r.ov = ov; r.rdy = rdy;
      return r;
   endfunction

   task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic play(input logic [3:0] pos);
      move_valid = 1'b1; move_pos = pos;
      step();
      move_valid = 1'b0;
      step();
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; move_valid = 1'b0; move_pos = '0;
      #2;
      chk("rst_ready", 9'(move_ready), 9'd0);
      chk("rst_ain", ain, 9'h000);
      chk("rst_over", 9'(game_over), 9'd0);
      chk("rst_winner", 9'(winner), 9'd0);
      @(negedge clk) rst_n = 1'b1;
      step();
      chk("idle_ready", 9'(move_ready), 9'd0);

      // Row win: A takes 8,7,6
      vecs.push_back(v(1,0,0, 9'h000,9'h000, 0,0,2'd0,0,1));
      vecs.push_back(v(0,1,8, 9'h100,9'h000, 0,0,2'd0,0,0));
      vecs.push_back(v(0,0,0, 9'h100,9'h000, 1,0,2'd0,0,1));
      vecs.push_back(v(0,1,3, 9'h100,9'h008, 1,0,2'd0,0,0));
      vecs.push_back(v(0,0,0, 9'h100,9'h008, 0,0,2'd0,0,1));
      vecs.push_back(v(0,1,7, 9'h180,9'h008, 0,0,2'd0,0,0));
      vecs.push_back(v(0,0,0, 9'h180,9'h008, 1,0,2'd0,0,1));
      vecs.push_back(v(0,1,4, 9'h180,9'h018, 1,0,2'd0,0,0));
      vecs.push_back(v(0,0,0, 9'h180,9'h018, 0,0,2'd0,0,1));
      vecs.push_back(v(0,1,6, 9'h1C0,9'h018, 0,0,2'd0,0,0));
      vecs.push_back(v(0,0,0, 9'h1C0,9'h018, 0,0,2'd1,1,0));
      vecs.push_back(v(0,1,0, 9'h1C0,9'h018, 0,0,2'd1,1,0));
      // Draw: 4,8,2,6,7,1,3,5,0
      vecs.push_back(v(1,0,0, 9'h000,9'h000, 0,0,2'd0,0,1));
      vecs.push_back(v(0,1,4, 9'h010,9'h000, 0,0,2'd0,0,0));
      vecs.push_back(v(0,0,0, 9'h010,9'h000, 1,0,2'd0,0,1));
      vecs.push_back(v(0,1,8, 9'h010,9'h100, 1,0,2'd0,0,0));
      vecs.push_back(v(0,0,0, 9'h010,9'h100, 0,0,2'd0,0,1));
      vecs.push_back(v(0,1,2, 9'h014,9'h100, 0,0,2'd0,0,0));
      vecs.push_back(v(0,0,0, 9'h014,9'h100, 1,0,2'd0,0,1));
      vecs.push_back(v(0,1,6, 9'h014,9'h140, 1,0,2'd0,0,0));
      vecs.push_back(v(0,0,0, 9'h014,9'h140, 0,0,2'd0,0,1));
      vecs.push_back(v(0,1,7, 9'h094,9'h140, 0,0,2'd0,0,0));
      vecs.push_back(v(0,0,0, 9'h094,9'h140, 1,0,2'd0,0,1));
      vecs.push_back(v(0,1,1, 9'h094,9'h142, 1,0,2'd0,0,0));
      vecs.push_back(v(0,0,0, 9'h094,9'h142, 0,0,2'd0,0,1));
      vecs.push_back(v(0,1,3, 9'h09C,9'h142, 0,0,2'd0,0,0));
      vecs.push_back(v(0,0,0, 9'h09C,9'h142, 1,0,2'd0,0,1));
      vecs.push_back(v(0,1,5, 9'h09C,9'h162, 1,0,2'd0,0,0));
      vecs.push_back(v(0,0,0, 9'h09C,9'h162, 0,0,2'd0,0,1));
      vecs.push_back(v(0,1,0, 9'h09D,9'h162, 0,0,2'd0,0,0));
      vecs.push_back(v(0,0,0, 9'h09D,9'h162, 0,0,2'd3,1,0));
      // Illegal: occupied cell, then out-of-range index
      vecs.push_back(v(1,0,0, 9'h000,9'h000, 0,0,2'd0,0,1));
      vecs.push_back(v(0,1,4, 9'h010,9'h000, 0,0,2'd0,0,0));
      vecs.push_back(v(0,0,0, 9'h010,9'h000, 1,0,2'd0,0,1));
      vecs.push_back(v(0,1,4, 9'h010,9'h000, 1,1,2'd0,0,1));
      vecs.push_back(v(0,1,9, 9'h010,9'h000, 1,1,2'd0,0,1));
      vecs.push_back(v(0,0,0, 9'h010,9'h000, 1,0,2'd0,0,1));
      vecs.push_back(v(0,1,0, 9'h010,9'h001, 1,0,2'd0,0,0));
      vecs.push_back(v(0,0,0, 9'h010,9'h001, 0,0,2'd0,0,1));
      // start with simultaneous move mid-game
      vecs.push_back(v(1,1,5, 9'h000,9'h000, 0,0,2'd0,0,1));
      vecs.push_back(v(0,0,0, 9'h000,9'h000, 0,0,2'd0,0,1));

      for (int i = 0; i < vecs.size(); i++) begin
         start = vecs[i].st; move_valid = vecs[i].mv; move_pos = vecs[i].pos;
         step();
         chk($sformatf("v%0d_ain", i), ain, vecs[i].a);
         chk($sformatf("v%0d_bin", i), bin, vecs[i].b);
         chk($sformatf("v%0d_turn", i), 9'(turn), 9'(vecs[i].t));
         chk($sformatf("v%0d_illegal", i), 9'(illegal), 9'(vecs[i].ill));
         chk($sformatf("v%0d_winner", i), 9'(winner), 9'(vecs[i].w));
         chk($sformatf("v%0d_over", i), 9'(game_over), 9'(vecs[i].ov));
         chk($sformatf("v%0d_ready", i), 9'(move_ready), 9'(vecs[i].rdy));
         chk($sformatf("v%0d_timeout", i), 9'(timeout), 9'd0);
      end
      start = 1'b0; move_valid = 1'b0; move_pos = '0;

      // Win on the ninth move (board full) reports A, not draw
      start = 1'b1; step(); start = 1'b0;
      play(8); play(5); play(7); play(4); play(2); play(1); play(3); play(0); play(6);
      chk("nine_ain", ain, 9'h1CC);
      chk("nine_bin", bin, 9'h033);
      chk("nine_winner", 9'(winner), 9'd1);
      chk("nine_over", 9'(game_over), 9'd1);

      // Reset asserted while in CHECK
      start = 1'b1; step(); start = 1'b0;
      move_valid = 1'b1; move_pos = 4'd4; step(); move_valid = 1'b0;
      chk("chk_ain", ain, 9'h010);
      chk("chk_ready", 9'(move_ready), 9'd0);
      rst_n = 1'b0;
      #1;
      chk("mrst_ain", ain, 9'h000);
      chk("mrst_bin", bin, 9'h000);
      chk("mrst_turn", 9'(turn), 9'd0);
      chk("mrst_winner", 9'(winner), 9'd0);
      chk("mrst_over", 9'(game_over), 9'd0);
      chk("mrst_illegal", 9'(illegal), 9'd0);
      chk("mrst_timeout", 9'(timeout), 9'd0);
      chk("mrst_ready", 9'(move_ready), 9'd0);
      @(negedge clk) rst_n = 1'b1;
      move_valid = 1'b1; move_pos = 4'd4; step(); move_valid = 1'b0;
      chk("nostart_ain", ain, 9'h000);
      chk("nostart_ready", 9'(move_ready), 9'd0);
      step();
      chk("nostart_over", 9'(game_over), 9'd0);

`ifdef TTT_MOVE_TIMEOUT_EN
      start = 1'b1; step(); start = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         step();
         chk($sformatf("to_wait%0d", i), 9'(timeout), 9'd0);
      end
      step();
      chk("to_pulse", 9'(timeout), 9'd1);
      chk("to_turn", 9'(turn), 9'd1);
      chk("to_illegal", 9'(illegal), 9'd0);
      step();
      chk("to_pulse_end", 9'(timeout), 9'd0);
      step(); step();
      chk("to_pre_move", 9'(timeout), 9'd0);
      move_valid = 1'b1; move_pos = 4'd0; step(); move_valid = 1'b0;
      chk("to_race_timeout", 9'(timeout), 9'd0);
      chk("to_race_bin", bin, 9'h001);
      step();
      chk("to_race_turn", 9'(turn), 9'd0);
      chk("to_race_after", 9'(timeout), 9'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
